// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction fetch sequencer for a multicycle core. Each instruction is
// fetched from instruction memory in FETCH, held for the control unit in
// ISSUE until the downstream data path stops stalling, and then retired.
// Retirement advances the PC (sequential, branch, jump or JR) or, on a halt
// decode, parks the unit in HALTED until the next reset.
//
// Ports
//   CLK         rising-edge clock for all state
//   RST         synchronous active-high reset
//   ihit        instruction memory returned iload for the current iaddr
//   iload       instruction word from instruction memory
//   iREN        instruction memory read request (registered)
//   iaddr       fetch address, which is the current PC
//   instr       instruction word presented to the control unit
//   instr_valid instr holds a fetched, not-yet-retired instruction (registered)
//   stall       downstream not finished, so hold the current instruction
//   brnch_eq    control decode: branch if equal
//   brnch_ne    control decode: branch if not equal
//   jmp         control decode: absolute jump (J/JAL)
//   JR          control decode: jump to register
//   cuHALT      control decode: halt
//   zero        ALU zero flag for the current instruction
//   rs_data     register rs value, used as the JR target
//   pc_plus4    PC+4 of the current instruction (JAL link value)
//   halted      sticky halt indication (registered)
//   retired     count of retired instructions, wraps mod 2^32

module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        brnch_eq,
  input  logic        brnch_ne,
  input  logic        jmp,
  input  logic        JR,
  input  logic        cuHALT,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        branch_taken;

  assign iaddr    = pc;
  assign pc_plus4 = pc + 32'd4;

  // Branch offset is the sign-extended word displacement; the add wraps
  // naturally in 32 bits.
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

  // Masking rather than slicing keeps every rs_data bit in use and keeps
  // the PC word aligned even for a misaligned register value.
  assign jr_target     = rs_data & 32'hFFFF_FFFC;

  assign branch_taken  = (brnch_eq & zero) | (brnch_ne & ~zero);

  // Next-PC selection, highest priority first. Only consumed on retire.
  always_comb begin
    next_pc = pc_plus4;
    if (cuHALT) begin
      next_pc = pc;
    end else if (JR) begin
      next_pc = jr_target;
    end else if (jmp) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  // Sequencer. iREN, instr_valid and halted are registered alongside the
  // state so they change exactly on the state transitions. Control inputs
  // only matter on the ISSUE/no-stall retire edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= FETCH;
      pc          <= {PC_RESET[31:2], 2'b00};
      instr       <= 32'h0000_0000;
      instr_valid <= 1'b0;
      iREN        <= 1'b1;
      halted      <= 1'b0;
      retired     <= 32'h0000_0000;
    end else begin
      case (state)
        FETCH: begin
          if (ihit) begin
            instr       <= iload;
            instr_valid <= 1'b1;
            iREN        <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            retired     <= retired + 32'd1;
            pc          <= next_pc;
            instr_valid <= 1'b0;
            if (cuHALT) begin
              iREN   <= 1'b0;
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              iREN  <= 1'b1;
              state <= FETCH;
            end
          end
        end
        HALTED: begin
          iREN        <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          state       <= FETCH;
          iREN        <= 1'b1;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// -------------
// Self-checking bench for fetch_unit. Expected fetch addresses are pushed
// to a scoreboard queue when the retiring stimulus is driven and popped
// when the unit is back in FETCH presenting its next address.

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        brnch_eq;
  logic        brnch_ne;
  logic        jmp;
  logic        JR;
  logic        cuHALT;
  logic        zero;
  logic [31:0] rs_data;
  logic [31:0] pc_plus4;
  logic        halted;
  logic [31:0] retired;

  int          total;
  int          bad;
  int          exp_retired;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  fetch_unit #(.PC_RESET(RESET_PC)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN),
    .iaddr(iaddr), .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .brnch_eq(brnch_eq), .brnch_ne(brnch_ne), .jmp(jmp), .JR(JR),
    .cuHALT(cuHALT), .zero(zero), .rs_data(rs_data), .pc_plus4(pc_plus4),
    .halted(halted), .retired(retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ctrl;
    brnch_eq = 1'b0; brnch_ne = 1'b0; jmp = 1'b0; JR = 1'b0;
    cuHALT = 1'b0; zero = 1'b0; rs_data = 32'h0;
  endtask

  task automatic do_reset;
    RST = 1'b1; ihit = 1'b0; iload = 32'h0; stall = 1'b0;
    clear_ctrl();
    tick();
    RST = 1'b0;
    exp_retired = 0;
    exp_q.delete();
  endtask

  task automatic do_fetch(input logic [31:0] word);
    ihit = 1'b1; iload = word;
    tick();
    ihit = 1'b0; iload = 32'h0;
  endtask

  task automatic do_retire(input logic beq, input logic bne, input logic z,
                           input logic j, input logic jr, input logic h,
                           input logic [31:0] rs);
    brnch_eq = beq; brnch_ne = bne; zero = z; jmp = j; JR = jr;
    cuHALT = h; rs_data = rs; stall = 1'b0;
    tick();
    clear_ctrl();
    exp_retired++;
  endtask

  // Steer the PC to an arbitrary word address through a JR retire.
  task automatic goto_pc(input logic [31:0] target);
    do_fetch(32'h0000_0000);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, target);
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if (iREN !== 1'b1) begin bad++; $display("[TB] FAIL reset_iren got=%b exp=1", iREN); end
    total++;
    if (iaddr !== RESET_PC) begin bad++; $display("[TB] FAIL reset_iaddr got=%h exp=%h", iaddr, RESET_PC); end
    total++;
    if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", instr_valid); end
    total++;
    if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
    total++;
    if (retired !== 32'd0) begin bad++; $display("[TB] FAIL reset_retired got=%0d exp=0", retired); end
    total++;
    if (instr !== 32'd0) begin bad++; $display("[TB] FAIL reset_instr got=%h exp=0", instr); end
  endtask

  task automatic test_sequential;
    logic [31:0] words[3];
    words[0] = 32'h2001_0001; words[1] = 32'h2002_0002; words[2] = 32'h2003_0003;
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    for (int i = 0; i < 3; i++) begin
      exp_v = exp_q.pop_front();
      total++;
      if (iREN !== 1'b1 || iaddr !== exp_v) begin
        bad++; $display("[TB] FAIL seq_fetch%0d iren=%b iaddr=%h exp_iaddr=%h", i, iREN, iaddr, exp_v);
      end
      do_fetch(words[i]);
      total++;
      if (instr_valid !== 1'b1 || iREN !== 1'b0 || instr !== words[i]) begin
        bad++; $display("[TB] FAIL seq_issue%0d valid=%b iren=%b instr=%h exp_instr=%h", i, instr_valid, iREN, instr, words[i]);
      end
      do_retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    total++;
    if (retired !== 32'd3) begin bad++; $display("[TB] FAIL seq_retired got=%0d exp=3", retired); end
    exp_v = exp_q.pop_front();
    total++;
    if (iaddr !== exp_v) begin bad++; $display("[TB] FAIL seq_last_iaddr got=%h exp=%h", iaddr, exp_v); end
  endtask

  task automatic test_branch;
    do_reset();
    // beq taken backwards: 0x14 + (-2 << 2) = 0x0C
    goto_pc(32'h10);
    do_fetch(32'h1000_FFFE);
    exp_q.push_back(32'h0C);
    do_retire(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_v = exp_q.pop_front();
    total++;
    if (iaddr !== exp_v) begin bad++; $display("[TB] FAIL beq_taken got=%h exp=%h", iaddr, exp_v); end
    // beq not taken
    goto_pc(32'h10);
    do_fetch(32'h1000_FFFE);
    exp_q.push_back(32'h14);
    do_retire(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_v = exp_q.pop_front();
    total++;
    if (iaddr !== exp_v) begin bad++; $display("[TB] FAIL beq_not_taken got=%h exp=%h", iaddr, exp_v); end
    // bne taken forward: 0x104 + (3 << 2) = 0x110
    goto_pc(32'h100);
    do_fetch(32'h1400_0003);
    exp_q.push_back(32'h110);
    do_retire(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_v = exp_q.pop_front();
    total++;
    if (iaddr !== exp_v) begin bad++; $display("[TB] FAIL bne_taken got=%h exp=%h", iaddr, exp_v); end
    // bne not taken when zero set
    goto_pc(32'h100);
    do_fetch(32'h1400_0003);
    exp_q.push_back(32'h104);
    do_retire(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_v = exp_q.pop_front();
    total++;
    if (iaddr !== exp_v) begin bad++; $display("[TB] FAIL bne_not_taken got=%h exp=%h", iaddr, exp_v); end
  endtask

  task automatic test_jump;
    do_reset();
    goto_pc(32'h40);
    do_fetch(32'h0800_0100);
    total++;
    if (pc_plus4 !== 32'h44) begin bad++; $display("[TB] FAIL jal_link got=%h exp=00000044", pc_plus4); end
    // jmp wins over a taken branch
    exp_q.push_back(32'h400);
    do_retire(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    exp_v = exp_q.pop_front();
    total++;
    if (iaddr !== exp_v) begin bad++; $display("[TB] FAIL jump got=%h exp=%h", iaddr, exp_v); end
    // JR wins over jmp, low bits cleared
    do_fetch(32'h0800_0100);
    exp_q.push_back(32'h1234);
    do_retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1237);
    exp_v = exp_q.pop_front();
    total++;
    if (iaddr !== exp_v) begin bad++; $display("[TB] FAIL jr got=%h exp=%h", iaddr, exp_v); end
    total++;
    if (retired !== exp_retired) begin bad++; $display("[TB] FAIL jump_retired got=%0d exp=%0d", retired, exp_retired); end
  endtask

  task automatic test_stall;
    do_reset();
    goto_pc(32'h20);
    do_fetch(32'hDEAD_BEEF);
    // Hold in ISSUE while waving ignored inputs around.
    stall = 1'b1; ihit = 1'b1; iload = 32'h1111_2222;
    cuHALT = 1'b1; jmp = 1'b1; JR = 1'b1; rs_data = 32'h800;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (instr !== 32'hDEAD_BEEF || iaddr !== 32'h20 || retired !== exp_retired ||
          instr_valid !== 1'b1 || iREN !== 1'b0 || halted !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_hold%0d instr=%h iaddr=%h retired=%0d valid=%b iren=%b halted=%b exp instr=deadbeef iaddr=00000020 retired=%0d valid=1 iren=0 halted=0",
                 i, instr, iaddr, retired, instr_valid, iREN, halted, exp_retired);
      end
    end
    ihit = 1'b0; iload = 32'h0; stall = 1'b0;
    exp_q.push_back(32'h24);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_v = exp_q.pop_front();
    // Wait in FETCH with control inputs asserted; none may matter.
    cuHALT = 1'b1; JR = 1'b1; rs_data = 32'h900; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (iREN !== 1'b1 || iaddr !== exp_v || instr_valid !== 1'b0 || retired !== exp_retired) begin
        bad++;
        $display("[TB] FAIL fetch_wait%0d iren=%b iaddr=%h valid=%b retired=%0d exp iren=1 iaddr=%h valid=0 retired=%0d",
                 i, iREN, iaddr, instr_valid, retired, exp_v, exp_retired);
      end
    end
    clear_ctrl(); stall = 1'b0;
  endtask

  task automatic test_halt;
    logic [31:0] held_pc;
    do_reset();
    goto_pc(32'h80);
    held_pc = 32'h80;
    do_fetch(32'hFC00_0000);
    do_retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h500);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (halted !== 1'b1 || iREN !== 1'b0 || instr_valid !== 1'b0 || iaddr !== held_pc ||
          retired !== exp_retired || instr !== 32'hFC00_0000) begin
        bad++;
        $display("[TB] FAIL halt_hold%0d halted=%b iren=%b valid=%b iaddr=%h retired=%0d instr=%h exp halted=1 iren=0 valid=0 iaddr=%h retired=%0d instr=fc000000",
                 i, halted, iREN, instr_valid, iaddr, retired, instr, held_pc, exp_retired);
      end
      ihit = 1'b1; iload = $urandom; stall = 1'($urandom_range(0, 1));
      JR = 1'b1; rs_data = $urandom; cuHALT = 1'($urandom_range(0, 1));
      tick();
    end
    ihit = 1'b0; clear_ctrl(); stall = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_retired = 0;
    total++;
    if (halted !== 1'b0 || iREN !== 1'b1 || iaddr !== RESET_PC || retired !== 32'd0) begin
      bad++;
      $display("[TB] FAIL halt_reset halted=%b iren=%b iaddr=%h retired=%0d exp halted=0 iren=1 iaddr=%h retired=0",
               halted, iREN, iaddr, retired, RESET_PC);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    goto_pc(32'hFFFF_FFFC);
    total++;
    if (pc_plus4 !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc_plus4 got=%h exp=00000000", pc_plus4); end
    do_fetch(32'h0000_0020);
    exp_q.push_back(32'h0);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_v = exp_q.pop_front();
    total++;
    if (iaddr !== exp_v) begin bad++; $display("[TB] FAIL wrap_iaddr got=%h exp=%h", iaddr, exp_v); end
  endtask

  // Reset landing on top of a retiring halt and on top of a fetch hit.
  task automatic test_back_to_back;
    do_reset();
    goto_pc(32'h60);
    do_fetch(32'h1234_5678);
    RST = 1'b1; cuHALT = 1'b1; stall = 1'b0; ihit = 1'b1; iload = 32'hAAAA_5555;
    tick();
    RST = 1'b0; clear_ctrl(); ihit = 1'b0;
    total++;
    if (halted !== 1'b0 || iREN !== 1'b1 || instr_valid !== 1'b0 || iaddr !== RESET_PC ||
        retired !== 32'd0 || instr !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_prio_issue halted=%b iren=%b valid=%b iaddr=%h retired=%0d instr=%h exp 0 1 0 %h 0 00000000",
               halted, iREN, instr_valid, iaddr, retired, instr, RESET_PC);
    end
    RST = 1'b1; ihit = 1'b1; iload = 32'hAAAA_5555;
    tick();
    RST = 1'b0; ihit = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || iREN !== 1'b1 || instr !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_prio_fetch valid=%b iren=%b instr=%h exp valid=0 iren=1 instr=00000000",
               instr_valid, iREN, instr);
    end
    exp_retired = 0;
  endtask

  initial begin
    total = 0; bad = 0; exp_retired = 0;
    RST = 1'b1; ihit = 1'b0; iload = 32'h0; stall = 1'b0;
    clear_ctrl();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_halt();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_RESET, default 32'h0000_0000, the word-aligned PC loaded on reset.
REQ-002 The block SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port ihit  input  1  instruction memory has returned iload for the current iaddr.
REQ-005 The block SHALL have port iload  input  32  instruction word from instruction memory.
REQ-006 The block SHALL have port iREN  output  1  instruction memory read request.
REQ-007 The block SHALL have port iaddr  output  32  fetch address, which is the current PC.
REQ-008 The block SHALL have port instr  output  32  instruction word presented to the control unit.
REQ-009 The block SHALL have port instr_valid  output  1  instr holds a fetched, not-yet-retired instruction.
REQ-010 The block SHALL have port stall  input  1  downstream (data memory) not finished, so hold the current instruction.
REQ-011 The block SHALL have ports brnch_eq, brnch_ne, jmp, JR and cuHALT, each input  1, carrying control unit decodes of instr.
REQ-012 The block SHALL have port zero  input  1  ALU zero flag for the current instruction.
REQ-013 The block SHALL have port rs_data  input  32  register rs value, used as the JR target.
REQ-014 The block SHALL have port pc_plus4  output  32  PC+4 of the current instruction, used as the JAL link value.
REQ-015 The block SHALL have port halted  output  1  sticky halt indication.
REQ-016 The block SHALL have port retired  output  32  count of retired instructions.

Function
REQ-017 The FSM SHALL have states FETCH, ISSUE and HALTED, and SHALL enter FETCH on reset.
REQ-018 In FETCH: iREN=1, iaddr=PC and instr_valid=0. On ihit, the block SHALL capture iload into instr and move to ISSUE on the next edge.
REQ-019 In FETCH without ihit, the block SHALL stay in FETCH with PC and iaddr unchanged, with no timeout.
REQ-020 In ISSUE: iREN=0 and instr_valid=1. instr SHALL hold stable while in ISSUE. ihit SHALL be ignored in ISSUE.
REQ-021 In ISSUE with stall=1, the block SHALL hold state, PC, instr and retired.
REQ-022 In ISSUE with stall=0, the block SHALL retire: increment retired (mod 2^32), update PC per REQ-023 and move to FETCH; if cuHALT=1, it SHALL go to HALTED instead.
REQ-023 The next-PC priority SHALL be cuHALT (PC unchanged) > JR (rs_data with bits [1:0] forced to 0) > jmp ({pc_plus4[31:28], instr[25:0], 2'b00}) > taken branch > pc_plus4.
REQ-024 A branch SHALL be taken when (brnch_eq AND zero) OR (brnch_ne AND NOT zero). The target SHALL be pc_plus4 + (sign-extended instr[15:0] << 2), computed in 32 bits with carry discarded.
REQ-025 pc_plus4 SHALL equal PC+4 mod 2^32, so PC 32'hFFFF_FFFC gives 32'h0000_0000.
REQ-026 PC bits [1:0] SHALL always be 0.
REQ-027 HALTED SHALL be absorbing until reset: iREN=0, instr_valid=0, halted=1, and PC, instr and retired frozen.
REQ-028 The minimum cycles per instruction SHALL be 2: one FETCH cycle with ihit, plus one ISSUE cycle with stall=0.
REQ-029 The control inputs SHALL be sampled only in ISSUE with stall=0; their values in any other state SHALL have no effect.

Reset
REQ-030 When RST=1 at a clock edge, the block SHALL set PC=PC_RESET, state=FETCH, instr=0, instr_valid=0, halted=0 and retired=0, regardless of state, including mid-fetch or while halted.
REQ-031 The first cycle after RST deasserts SHALL drive iREN=1 and iaddr=PC_RESET.
REQ-032 RST SHALL take priority over ihit, stall and cuHALT in the same cycle.

Verification
REQ-033 Sequential fetch check: reset; ihit=1 each FETCH cycle; no control asserted -> iaddr sequence 0, 4, 8, one new address every 2 cycles; retired = 3 after 6 cycles.
REQ-034 Branch check: PC=0x10; instr imm=16'hFFFE; brnch_eq=1, zero=1 -> next iaddr=0x0C. Same stimulus with zero=0 -> next iaddr=0x14.
REQ-035 Jump and JR check: PC=0x40, instr[25:0]=26'h100, jmp=1 -> next iaddr=0x400. JR=1 with jmp=1 and rs_data=0x1237 -> next iaddr=0x1234.
REQ-036 Stall and wait check: ISSUE with stall=1 held for 5 cycles -> instr, PC and retired unchanged. FETCH with ihit=0 for 4 cycles -> iREN=1, iaddr constant.
REQ-037 Halt and reset check: cuHALT=1 in ISSUE -> halted=1 and iREN=0 forever after, retired incremented once. Then RST=1 for one cycle -> halted=0, iaddr=PC_RESET, retired=0.
REQ-038 Wrap check: PC=0xFFFF_FFFC with sequential retire -> next iaddr=0x0000_0000.
